// File: rtl/led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl
//   Multiplexed 7-segment display scanner with hex glyph decode, leading-zero
//   blanking and a debounced push button that freezes the displayed value.
//
// Ports
//   clk       in   1            system clock, rising edge
//   rst_n     in   1            asynchronous active-low reset
//   button    in   1            raw push button, 1 = pressed
//   value     in   4*N_DIGITS   hex nibble per digit, digit 0 rightmost
//   dp        in   N_DIGITS     decimal point per digit, 1 = lit
//   blank_lz  in   1            1 = blank leading zeros
//   led_en    out  N_DIGITS     digit anodes, active-low
//   led_cx    out  8            segments CA..CG in [6:0], DP in [7], active-low
//   frozen    out  1            1 = display shows the captured snapshot
// -----------------------------------------------------------------------------
module led_scan_ctrl #(
    parameter int N_DIGITS   = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    button,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    blank_lz,
    output logic [N_DIGITS-1:0]     led_en,
    output logic [7:0]              led_cx,
    output logic                    frozen
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DEB_W = $clog2(DEB_CYCLES);

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // ---------------------------------------------------------------- scan
    logic [DIV_W-1:0]       r_div;
    logic [IDX_W-1:0]       r_idx;
    logic [N_DIGITS-1:0]    r_led_en;
    logic [7:0]             r_led_cx;
    logic                   w_tick;

    assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // ---------------------------------------------------------- debounce
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_deb;
    logic                   r_deb_d;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic                   w_rise;

    // With a 1-bit level, "differs from the debounced level" is the same as
    // "equals the new level", so the counter restarts on any bounce back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_d   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_deb     <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    assign w_rise = r_deb & ~r_deb_d;

    // ------------------------------------------------------------ freeze
    logic                   r_frozen;
    logic [4*N_DIGITS-1:0]  r_snap_val;
    logic [N_DIGITS-1:0]    r_snap_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frozen   <= 1'b0;
            r_snap_val <= '0;
            r_snap_dp  <= '0;
        end else if (w_rise) begin
            r_frozen <= ~r_frozen;
            if (!r_frozen) begin
                r_snap_val <= value;
                r_snap_dp  <= dp;
            end
        end
    end

    // ---------------------------------------------------- glyph selection
    logic [4*N_DIGITS-1:0]  w_src_val;
    logic [N_DIGITS-1:0]    w_src_dp;
    logic [3:0]             w_nib;
    logic                   w_dp_bit;
    logic                   w_blank;
    logic [7:0]             w_cx;

    assign w_src_val = r_frozen ? r_snap_val : value;
    assign w_src_dp  = r_frozen ? r_snap_dp  : dp;

    // Walk from the top digit down, tracking whether everything above (and
    // including) the current digit is zero; digit 0 is never blanked.
    always_comb begin
        logic w_zero_above;
        w_nib        = 4'h0;
        w_dp_bit     = 1'b0;
        w_blank      = 1'b0;
        w_zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (w_src_val[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_nib    = w_src_val[4*i +: 4];
                w_dp_bit = w_src_dp[i];
                w_blank  = blank_lz && (i != 0) && w_zero_above;
            end
        end
    end

    assign w_cx = {~w_dp_bit, w_blank ? 7'h7F : hex_glyph(w_nib)};

    // Anode and segments are loaded on the same edge so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_en <= '1;
            r_led_cx <= 8'hFF;
        end else if (w_tick) begin
            r_led_en <= ~(N_DIGITS'(1) << r_idx);
            r_led_cx <= w_cx;
        end
    end

    assign led_en = r_led_en;
    assign led_cx = r_led_cx;
    assign frozen = r_frozen;

endmodule

// File: tb/tb_led_scan_ctrl.sv
module tb_led_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        button;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  led_en;
    logic [7:0]  led_cx;
    logic        frozen;

    logic        button1;
    logic [3:0]  value1;
    logic [0:0]  dp1;
    logic        blank1;
    logic [0:0]  led_en1;
    logic [7:0]  led_cx1;
    logic        frozen1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    led_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(4), .DEB_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .value(value), .dp(dp),
        .blank_lz(blank_lz), .led_en(led_en), .led_cx(led_cx), .frozen(frozen)
    );

    led_scan_ctrl #(.N_DIGITS(1), .SCAN_DIV(4), .DEB_CYCLES(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .button(button1), .value(value1), .dp(dp1),
        .blank_lz(blank1), .led_en(led_en1), .led_cx(led_cx1), .frozen(frozen1)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] ref_cx(input logic [15:0] v, input logic [3:0] d,
                                          input logic bl, input int dig);
        int hi = -1;
        logic [7:0] g;
        for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) hi = k;
        g = ref_glyph(v[4*dig +: 4]);
        if (bl && dig > 0 && dig > hi) g[6:0] = 7'h7F;
        g[7] = ~d[dig];
        return g;
    endfunction

    // Expected frame pushed when the stimulus is in place, popped one digit
    // per scan tick and held-checked for the whole slot.
    task automatic scan_frame(input string tag, input logic [15:0] v, input logic [3:0] d,
                              input logic bl);
        int k = 0;
        int d0;
        logic [11:0] e;
        @(negedge clk);
        while (!(cyc >= 4 && cyc % 4 == 0) && k < 16) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_sync"}, (k < 16) ? 32'd1 : 32'd0, 32'd1);
        d0 = (cyc / 4 - 1) % 4;
        for (int j = 0; j < 4; j++) begin
            int dg = (d0 + j) % 4;
            logic [3:0] en = 4'b0001 << dg;
            sb_q.push_back({~en, ref_cx(v, d, bl, dg)});
        end
        for (int j = 0; j < 4; j++) begin
            e = sb_q.pop_front();
            for (int h = 0; h < 4; h++) begin
                check({tag, "_en"}, {28'd0, led_en}, {28'd0, e[11:8]});
                check({tag, "_cx"}, {24'd0, led_cx}, {24'd0, e[7:0]});
                @(negedge clk);
            end
        end
        check({tag, "_n1_en"}, {31'd0, led_en1}, 32'd0);
        check({tag, "_n1_cx"}, {24'd0, led_cx1}, 32'h80);
    endtask

    task automatic press_latency(input string tag, input logic exp_frozen);
        int lat = 99;
        button = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (frozen === exp_frozen) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 11);
        check({tag, "_frozen"}, {31'd0, frozen}, {31'd0, exp_frozen});
        repeat (9) @(negedge clk);
        button = 1'b0;
        repeat (30) @(negedge clk);
        check({tag, "_after_release"}, {31'd0, frozen}, {31'd0, exp_frozen});
    endtask

    initial begin
        rst_n    = 1'b0;
        button   = 1'b0;
        value    = 16'h12AF;
        dp       = 4'h0;
        blank_lz = 1'b0;
        button1  = 1'b0;
        value1   = 4'h8;
        dp1      = 1'b0;
        blank1   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_en", {28'd0, led_en}, 32'hF);
        check("rst_cx", {24'd0, led_cx}, 32'hFF);
        check("rst_frozen", {31'd0, frozen}, 32'd0);
        rst_n = 1'b1;

        // V1: nothing shown until the first tick
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("pre_tick_en", {28'd0, led_en}, 32'hF);
            check("pre_tick_cx", {24'd0, led_cx}, 32'hFF);
        end
        check("pre_tick_n1_en", {31'd0, led_en1}, 32'd1);
        check("pre_tick_n1_cx", {24'd0, led_cx1}, 32'hFF);

        scan_frame("v1a", 16'h12AF, 4'h0, 1'b0);
        scan_frame("v1b", 16'h12AF, 4'h0, 1'b0);

        // V2: leading-zero blanking
        value = 16'h0030; blank_lz = 1'b1;
        scan_frame("v2a", 16'h0030, 4'h0, 1'b1);
        value = 16'h0000;
        scan_frame("v2b", 16'h0000, 4'h0, 1'b1);
        value = 16'h0700;
        scan_frame("v2c", 16'h0700, 4'h0, 1'b1);

        // V3: decimal point
        value = 16'h0000; blank_lz = 1'b0; dp = 4'b0001;
        scan_frame("v3", 16'h0000, 4'b0001, 1'b0);
        dp = 4'b0101; blank_lz = 1'b1;
        scan_frame("v3b", 16'h0000, 4'b0101, 1'b1);

        // V4: glitch, freeze, unfreeze
        value = 16'h12AF; dp = 4'h0; blank_lz = 1'b0;
        button = 1'b1;
        repeat (5) @(negedge clk);
        button = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_frozen", {31'd0, frozen}, 32'd0);

        press_latency("press1", 1'b1);
        value = 16'h5555;
        scan_frame("frozen_disp", 16'h12AF, 4'h0, 1'b0);
        press_latency("press2", 1'b0);
        scan_frame("live_disp", 16'h5555, 4'h0, 1'b0);

        // V5: reset mid-scan while frozen with a press in flight
        press_latency("press3", 1'b1);
        value = 16'h3C3C;
        button = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", {28'd0, led_en}, 32'hF);
        check("mid_rst_cx", {24'd0, led_cx}, 32'hFF);
        check("mid_rst_frozen", {31'd0, frozen}, 32'd0);
        check("mid_rst_n1_en", {31'd0, led_en1}, 32'd1);
        button = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_frozen", {31'd0, frozen}, 32'd0);
        scan_frame("post_rst_live", 16'h3C3C, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
